// File: rtl/checkpoint_ctrl.sv
// Branch-checkpoint controller: allocates RAT checkpoint slots in rename order,
// retires them in order, and sequences misprediction recovery.
module checkpoint_ctrl #(
  parameter int unsigned CP_NUM        = 4,
  parameter int unsigned CP_INDEX_SIZE = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     br_req,
  input  logic                     resolve_valid,
  input  logic [CP_INDEX_SIZE-1:0] resolve_tag,
  input  logic                     resolve_mispredict,
  output logic                     pause,
  output logic                     cp_check,
  output logic [CP_INDEX_SIZE-1:0] cp_target_index,
  output logic                     cp_request,
  output logic [CP_INDEX_SIZE-1:0] cp_request_index,
  output logic                     recover,
  output logic [CP_INDEX_SIZE:0]   free_count,
  output logic                     full
);

  localparam int unsigned IDX_W = CP_INDEX_SIZE;
  localparam int unsigned CNT_W = CP_INDEX_SIZE + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESTORE,
    ST_APPLY
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_head;
  logic [IDX_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [CP_NUM-1:0]  r_valid;
  logic [CP_NUM-1:0]  r_done;
  logic [IDX_W-1:0]   r_rec_tag;
  logic [CNT_W-1:0]   r_free_count;
  logic               r_full;

  logic               w_res_hit;
  logic               w_mispredict;
  logic               w_correct;
  logic               w_grant;
  logic               w_retire;
  logic [IDX_W-1:0]   w_mp_off;
  logic [CP_NUM-1:0]  w_squash;
  logic [CNT_W-1:0]   w_count_nxt;

  // Resolve decode; a resolve to an unallocated slot is ignored everywhere.
  always_comb begin
    w_res_hit    = resolve_valid & r_valid[resolve_tag];
    w_mispredict = w_res_hit & resolve_mispredict;
    w_correct    = w_res_hit & ~resolve_mispredict;
    w_grant      = br_req & (r_count < CNT_W'(CP_NUM)) & (r_state == ST_IDLE)
                   & ~flush & ~w_mispredict;
    w_retire     = r_valid[r_head]
                   & (r_done[r_head] | (w_correct & (resolve_tag == r_head)))
                   & ~w_mispredict & ~flush;
    w_mp_off     = IDX_W'(resolve_tag - r_head);
  end

  // Squash the mispredicted slot and everything younger (age measured from head).
  always_comb begin
    w_squash = '0;
    for (int i = 0; i < CP_NUM; i++) begin
      w_squash[i] = (IDX_W'(IDX_W'(i) - r_head) >= w_mp_off);
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else if (w_mispredict) begin
      w_count_nxt = CNT_W'(w_mp_off);
    end else begin
      w_count_nxt = r_count + CNT_W'(w_grant) - CNT_W'(w_retire);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_valid   <= '0;
      r_done    <= '0;
      r_rec_tag <= '0;
    end else if (w_mispredict) begin
      r_valid   <= r_valid & ~w_squash;
      r_done    <= r_done & ~w_squash;
      r_tail    <= resolve_tag;
      r_rec_tag <= resolve_tag;
    end else begin
      if (w_correct) begin
        r_done[resolve_tag] <= 1'b1;
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + IDX_W'(1);
      end
      if (w_grant) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= r_tail + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count      <= '0;
      r_free_count <= CNT_W'(CP_NUM);
      r_full       <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_free_count <= CNT_W'(CP_NUM) - w_count_nxt;
      r_full       <= (w_count_nxt == CNT_W'(CP_NUM));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Recovery sequencing; a new mispredict always restarts from RESTORE.
  always_comb begin
    w_state_nxt      = r_state;
    cp_request       = 1'b0;
    cp_request_index = '0;
    recover          = 1'b0;
    case (r_state)
      ST_IDLE: ;
      ST_RESTORE: begin
        cp_request       = 1'b1;
        cp_request_index = r_rec_tag;
        w_state_nxt      = ST_APPLY;
      end
      ST_APPLY: begin
        recover     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else if (w_mispredict) begin
      w_state_nxt = ST_RESTORE;
    end
  end

  always_comb begin
    pause           = (r_state != ST_IDLE) | flush | (br_req & ~w_grant);
    cp_check        = w_grant;
    cp_target_index = w_grant ? r_tail : '0;
    free_count      = r_free_count;
    full            = r_full;
  end

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// Directed self-checking bench for checkpoint_ctrl.
module tb_checkpoint_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic       br_req;
  logic       resolve_valid;
  logic [1:0] resolve_tag;
  logic       resolve_mispredict;
  logic       pause;
  logic       cp_check;
  logic [1:0] cp_target_index;
  logic       cp_request;
  logic [1:0] cp_request_index;
  logic       recover;
  logic [2:0] free_count;
  logic       full;

  int n_pass  = 0;
  int n_total = 0;

  checkpoint_ctrl #(.CP_NUM(4), .CP_INDEX_SIZE(2)) dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .br_req             (br_req),
    .resolve_valid      (resolve_valid),
    .resolve_tag        (resolve_tag),
    .resolve_mispredict (resolve_mispredict),
    .pause              (pause),
    .cp_check           (cp_check),
    .cp_target_index    (cp_target_index),
    .cp_request         (cp_request),
    .cp_request_index   (cp_request_index),
    .recover            (recover),
    .free_count         (free_count),
    .full               (full)
  );

  always #5 clock = ~clock;

  // Advance past the next active edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; br_req = 0; resolve_valid = 0; resolve_tag = 0; resolve_mispredict = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic alloc(input int n);
    for (int i = 0; i < n; i++) begin
      br_req = 1;
      tick();
    end
    br_req = 0;
  endtask

  task automatic resolve(input logic [1:0] tag, input logic mp);
    resolve_valid = 1; resolve_tag = tag; resolve_mispredict = mp;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++; if (pause !== 1'b0) $display("FAIL reset_pause got=%0b exp=0", pause); else n_pass++;
    n_total++; if (cp_check !== 1'b0) $display("FAIL reset_cp_check got=%0b exp=0", cp_check); else n_pass++;
    n_total++; if (cp_target_index !== 2'd0) $display("FAIL reset_target got=%0d exp=0", cp_target_index); else n_pass++;
    n_total++; if (cp_request !== 1'b0) $display("FAIL reset_request got=%0b exp=0", cp_request); else n_pass++;
    n_total++; if (cp_request_index !== 2'd0) $display("FAIL reset_req_idx got=%0d exp=0", cp_request_index); else n_pass++;
    n_total++; if (recover !== 1'b0) $display("FAIL reset_recover got=%0b exp=0", recover); else n_pass++;
    n_total++; if (free_count !== 3'd4) $display("FAIL reset_free got=%0d exp=4", free_count); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL reset_full got=%0b exp=0", full); else n_pass++;
  endtask

  task automatic test_fill_and_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      br_req = 1;
      #1;
      n_total++; if (cp_check !== 1'b1) $display("FAIL fill_check[%0d] got=%0b exp=1", i, cp_check); else n_pass++;
      n_total++; if (cp_target_index !== 2'(i)) $display("FAIL fill_tag[%0d] got=%0d exp=%0d", i, cp_target_index, i); else n_pass++;
      n_total++; if (pause !== 1'b0) $display("FAIL fill_pause[%0d] got=%0b exp=0", i, pause); else n_pass++;
      tick();
    end
    #1;
    n_total++; if (full !== 1'b1) $display("FAIL fill_full got=%0b exp=1", full); else n_pass++;
    n_total++; if (free_count !== 3'd0) $display("FAIL fill_free got=%0d exp=0", free_count); else n_pass++;
    n_total++; if (pause !== 1'b1) $display("FAIL fill_5th_pause got=%0b exp=1", pause); else n_pass++;
    n_total++; if (cp_check !== 1'b0) $display("FAIL fill_5th_check got=%0b exp=0", cp_check); else n_pass++;
    // Freeing slot 0 while full must not bypass into a same-cycle grant.
    resolve(2'd0, 1'b0);
    #1;
    n_total++; if (cp_check !== 1'b0) $display("FAIL wrap_nobypass got=%0b exp=0", cp_check); else n_pass++;
    tick();
    resolve_valid = 0;
    #1;
    n_total++; if (free_count !== 3'd1) $display("FAIL wrap_free got=%0d exp=1", free_count); else n_pass++;
    n_total++; if (cp_check !== 1'b1) $display("FAIL wrap_check got=%0b exp=1", cp_check); else n_pass++;
    n_total++; if (cp_target_index !== 2'd0) $display("FAIL wrap_tag got=%0d exp=0", cp_target_index); else n_pass++;
    tick();
    br_req = 0;
    n_total++; if (full !== 1'b1) $display("FAIL wrap_full got=%0b exp=1", full); else n_pass++;
  endtask

  task automatic test_in_order_retire();
    do_reset();
    alloc(4);
    resolve(2'd2, 1'b0); tick();
    n_total++; if (free_count !== 3'd0) $display("FAIL ooo_after2 got=%0d exp=0", free_count); else n_pass++;
    resolve(2'd1, 1'b0); tick();
    n_total++; if (free_count !== 3'd0) $display("FAIL ooo_after1 got=%0d exp=0", free_count); else n_pass++;
    resolve(2'd0, 1'b0); tick();
    resolve_valid = 0;
    n_total++; if (free_count !== 3'd1) $display("FAIL ooo_retire0 got=%0d exp=1", free_count); else n_pass++;
    tick();
    n_total++; if (free_count !== 3'd2) $display("FAIL ooo_retire1 got=%0d exp=2", free_count); else n_pass++;
    tick();
    n_total++; if (free_count !== 3'd3) $display("FAIL ooo_retire2 got=%0d exp=3", free_count); else n_pass++;
    tick();
    n_total++; if (free_count !== 3'd3) $display("FAIL ooo_hold3 got=%0d exp=3", free_count); else n_pass++;
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc(4);
    resolve(2'd1, 1'b1); br_req = 1;
    #1;
    n_total++; if (pause !== 1'b1) $display("FAIL mp_n_pause got=%0b exp=1", pause); else n_pass++;
    n_total++; if (cp_check !== 1'b0) $display("FAIL mp_n_check got=%0b exp=0", cp_check); else n_pass++;
    tick();
    resolve_valid = 0;
    #1;
    n_total++; if (cp_request !== 1'b1) $display("FAIL mp_n1_request got=%0b exp=1", cp_request); else n_pass++;
    n_total++; if (cp_request_index !== 2'd1) $display("FAIL mp_n1_idx got=%0d exp=1", cp_request_index); else n_pass++;
    n_total++; if (pause !== 1'b1) $display("FAIL mp_n1_pause got=%0b exp=1", pause); else n_pass++;
    n_total++; if (recover !== 1'b0) $display("FAIL mp_n1_recover got=%0b exp=0", recover); else n_pass++;
    n_total++; if (free_count !== 3'd3) $display("FAIL mp_n1_free got=%0d exp=3", free_count); else n_pass++;
    tick();
    n_total++; if (recover !== 1'b1) $display("FAIL mp_n2_recover got=%0b exp=1", recover); else n_pass++;
    n_total++; if (pause !== 1'b1) $display("FAIL mp_n2_pause got=%0b exp=1", pause); else n_pass++;
    n_total++; if (cp_request !== 1'b0) $display("FAIL mp_n2_request got=%0b exp=0", cp_request); else n_pass++;
    tick();
    n_total++; if (pause !== 1'b0) $display("FAIL mp_n3_pause got=%0b exp=0", pause); else n_pass++;
    n_total++; if (cp_check !== 1'b1) $display("FAIL mp_n3_check got=%0b exp=1", cp_check); else n_pass++;
    n_total++; if (cp_target_index !== 2'd1) $display("FAIL mp_n3_tag got=%0d exp=1", cp_target_index); else n_pass++;
    tick();
    br_req = 0;
    n_total++; if (free_count !== 3'd2) $display("FAIL mp_n3_free got=%0d exp=2", free_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc(4);
    resolve(2'd2, 1'b1); br_req = 1;
    tick();
    n_total++; if (cp_request_index !== 2'd2) $display("FAIL b2b_n1_idx got=%0d exp=2", cp_request_index); else n_pass++;
    n_total++; if (free_count !== 3'd2) $display("FAIL b2b_n1_free got=%0d exp=2", free_count); else n_pass++;
    resolve(2'd0, 1'b1);
    tick();
    // Slot 3 was squashed, so this mispredict must not restart recovery.
    resolve(2'd3, 1'b1);
    #1;
    n_total++; if (cp_request !== 1'b1) $display("FAIL b2b_n2_request got=%0b exp=1", cp_request); else n_pass++;
    n_total++; if (cp_request_index !== 2'd0) $display("FAIL b2b_n2_idx got=%0d exp=0", cp_request_index); else n_pass++;
    n_total++; if (free_count !== 3'd4) $display("FAIL b2b_n2_free got=%0d exp=4", free_count); else n_pass++;
    tick();
    resolve_valid = 0;
    n_total++; if (recover !== 1'b1) $display("FAIL b2b_n3_recover got=%0b exp=1", recover); else n_pass++;
    n_total++; if (cp_request !== 1'b0) $display("FAIL b2b_n3_request got=%0b exp=0", cp_request); else n_pass++;
    tick();
    n_total++; if (cp_check !== 1'b1) $display("FAIL b2b_n4_check got=%0b exp=1", cp_check); else n_pass++;
    n_total++; if (cp_target_index !== 2'd0) $display("FAIL b2b_n4_tag got=%0d exp=0", cp_target_index); else n_pass++;
    tick();
    br_req = 0;
    n_total++; if (free_count !== 3'd3) $display("FAIL b2b_n4_free got=%0d exp=3", free_count); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    alloc(2);
    flush = 1; br_req = 1; resolve(2'd0, 1'b1);
    #1;
    n_total++; if (cp_check !== 1'b0) $display("FAIL flush_check got=%0b exp=0", cp_check); else n_pass++;
    n_total++; if (pause !== 1'b1) $display("FAIL flush_pause got=%0b exp=1", pause); else n_pass++;
    tick();
    idle_inputs();
    #1;
    n_total++; if (free_count !== 3'd4) $display("FAIL flush_free got=%0d exp=4", free_count); else n_pass++;
    n_total++; if (cp_request !== 1'b0) $display("FAIL flush_request got=%0b exp=0", cp_request); else n_pass++;
    n_total++; if (pause !== 1'b0) $display("FAIL flush_idle_pause got=%0b exp=0", pause); else n_pass++;
    tick();
    n_total++; if (recover !== 1'b0) $display("FAIL flush_recover got=%0b exp=0", recover); else n_pass++;
    br_req = 1;
    #1;
    n_total++; if (cp_target_index !== 2'd0 || cp_check !== 1'b1) $display("FAIL flush_regrant got=%0b/%0d exp=1/0", cp_check, cp_target_index); else n_pass++;
    tick();
    br_req = 0;
  endtask

  initial begin
    test_reset();
    test_fill_and_wrap();
    test_in_order_retire();
    test_mispredict();
    test_back_to_back();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/checkpoint_ctrl.md
# checkpoint_ctrl

Branch-checkpoint controller for the rename stage. It allocates the `CP_NUM` RAT checkpoint slots to branches in rename order and drives the save port of `check_point` (`check`, `target_index`). It tracks branch resolution, frees slots in order, and sequences misprediction recovery (`request` → `recover`). Rename is stalled through `pause` whenever a slot cannot be granted or recovery is in flight.

## Interface
Parameters:
- `CP_NUM`, 4, number of checkpoint slots (power of two)
- `CP_INDEX_SIZE`, 2, log2(`CP_NUM`)

Ports:
- `clock` in 1: the block's single clock
- `reset` in 1: synchronous, active-high
- `flush` in 1: full pipeline flush; all slots are discarded
- `br_req` in 1: the current rename group contains a branch; at most one per group, guaranteed upstream
- `resolve_valid` in 1: a branch resolution is presented
- `resolve_tag` in `CP_INDEX_SIZE`: slot of the resolving branch
- `resolve_mispredict` in 1: the resolution is a misprediction
- `pause` out 1: stall rename this cycle
- `cp_check` out 1: save `check_point` slot this cycle; equals a grant
- `cp_target_index` out `CP_INDEX_SIZE`: slot saved, also the branch tag returned to rename
- `cp_request` out 1: read `check_point` slot
- `cp_request_index` out `CP_INDEX_SIZE`: slot read
- `recover` out 1: `checkpoint_out` is valid; mapping table and free list restore
- `free_count` out `CP_INDEX_SIZE+1`: free slots, registered
- `full` out 1: `free_count` == 0

## Operation
- State: `head` and `tail` (each `CP_INDEX_SIZE`, wrap mod `CP_NUM`), `count` (`CP_INDEX_SIZE+1`), `cp_valid[CP_NUM]`, `cp_done[CP_NUM]`, FSM {IDLE, RESTORE, APPLY}, `rec_tag`.
- `free_count` = `CP_NUM` − `count`.
- **Grant.** `grant` = `br_req` & `count` < `CP_NUM` & FSM==IDLE & !`flush` & !(`resolve_valid` & `resolve_mispredict` & `cp_valid[resolve_tag]`).
  - `grant` only affects allocation; the mispredict term blocks allocation in the same cycle.
  - On grant: `cp_check`=1 and `cp_target_index`=`tail`.
  - At the edge: `cp_valid[tail]`←1, `cp_done[tail]`←0, `tail`++, `count`++.
- **pause** = (FSM != IDLE) | `flush` | (`br_req` & !`grant`). All terms are combinational.
- **Any resolve with `cp_valid[resolve_tag]`=0** is ignored in every state.
- **Correct resolve** (valid tag, !mispredict): `cp_done[tag]`←1.
- **Retire.** If `cp_valid[head]` and (`cp_done[head]`, or head is being marked done this cycle): `cp_valid[head]`←0, `head`++, `count`--.
  - At most one retire per cycle.
  - A slot freed in cycle N is grantable from N+1; there is no same-cycle bypass when full.
- **Mispredict** (valid tag t, any FSM state):
  - `cp_valid`/`cp_done` of slots t .. `tail`−1 (mod) are cleared.
  - `tail`←t, `count`←(t−`head`) mod `CP_NUM`, `rec_tag`←t, FSM←RESTORE.
  - Retire is suppressed in that cycle.
  - Because squash invalidates `rec_tag` and everything younger, a valid tag during RESTORE/APPLY is always older. Recovery therefore restarts on the older branch.
- **FSM:**
  - IDLE: waits for a mispredict.
  - RESTORE: `cp_request`=1, `cp_request_index`=`rec_tag`; goes to APPLY.
  - APPLY: `recover`=1 (`check_point` output is registered, so data is valid now); goes to IDLE.
  - A mispredict in RESTORE or APPLY overrides and returns the FSM to RESTORE.
- **Squashed-slot contents.** A squashed slot's stored checkpoint stays intact until the next grant. No grant occurs before IDLE.
- **flush:** `head`=`tail`=0, `count`=0, all valid/done bits cleared, FSM IDLE. `flush` has priority over every other event in the same cycle.
- **reset:** same state as flush. Outputs after reset:
  - `pause`=0, `cp_check`=0, `cp_target_index`=0
  - `cp_request`=0, `cp_request_index`=0, `recover`=0
  - `free_count`=`CP_NUM`, `full`=0

## Timing
- Grant is same-cycle combinational from `br_req`. The tag is visible in cycle N, and the state update takes effect at the N+1 edge.
- Mispredict accepted in cycle N (IDLE):
  - N: `pause`=1.
  - N+1: RESTORE, `cp_request`=1, `pause`=1.
  - N+2: APPLY, `recover`=1, `pause`=1.
  - N+3: IDLE; a `br_req` is granted if `count` < `CP_NUM`.
- Correct resolve of the head in cycle N frees the slot at the N+1 edge. A correct resolve of a non-head slot frees it once every older slot has retired, one slot per cycle.
- `free_count`/`full` are registered; they reflect the edge just taken.

## Test plan
- Reset, then `br_req` for 4 consecutive cycles → `cp_target_index` 0,1,2,3 with `cp_check`=1. 5th cycle → `pause`=1, `cp_check`=0, `full`=1.
- Full; correct resolve of tag 0 in cycle N with `br_req` held → no grant in N; grant with `cp_target_index`=0 in N+1 (wrap-around).
- Tags 0-3 allocated; correct resolves 2 then 1 then 0 → nothing retires until 0 resolves. Then one retire per cycle, and `free_count` goes 1,2,3.
- Tags 0-3 allocated; mispredict tag 1 at N → `cp_request`/index 1 at N+1, `recover` at N+2, `pause` high N..N+2. `free_count`=3 at N+1, and the next grant returns tag 1.
- Mispredict tag 2 at N, then mispredict tag 0 at N+1 → FSM back to RESTORE at N+2 with index 0, `recover` at N+3, `count`=0. A resolve of tag 3 in that window is ignored.
- `flush` in the same cycle as `br_req` and a mispredict → no `cp_check`, no recovery. Next cycle: `free_count`=4 and FSM IDLE.
